// File: rtl/bcd2bin_seq.sv
// Sequential three-digit BCD to signed binary converter using reverse double-dabble.
// One iteration per clock; the result and error flag are registered and held until the next request.
module bcd2bin_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [11:0]        bcd,
  input  logic               negative,
  output logic signed [10:0] binary,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [11:0]        r_bcd;
  logic [9:0]         r_bin;
  logic               r_neg;
  logic [3:0]         r_cnt;
  logic signed [10:0] r_binary;
  logic               r_error;
  logic [21:0]        w_step;
  logic               w_bad;
  logic               w_last;

  function automatic logic digits_bad(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  // Shift right, then pull each BCD digit that reached 8 or more back down by 3.
  function automatic logic [21:0] dabble_step(input logic [21:0] v);
    logic [21:0] s;
    s = v >> 1;
    for (int d = 0; d < 3; d++) begin
      if (s[13 + 4*d]) s[10 + 4*d +: 4] = s[10 + 4*d +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic signed [10:0] apply_sign(input logic [9:0] mag, input logic neg);
    logic signed [10:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

  assign w_step = dabble_step({r_bcd, r_bin});
  assign w_bad  = digits_bad(bcd);
  assign w_last = (r_cnt == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = w_bad ? DONE : SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The final iteration and the DONE entry share one edge, so the result comes from w_step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_binary <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_bcd <= bcd;
          r_bin <= '0;
          r_neg <= negative;
          r_cnt <= '0;
          if (w_bad) begin
            r_error  <= 1'b1;
            r_binary <= '0;
          end else begin
            r_error  <= 1'b0;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= w_step;
          r_cnt          <= r_cnt + 4'd1;
          if (w_last) r_binary <= apply_sign(w_step[9:0], r_neg);
        end
        default: ;
      endcase
    end
  end

  assign binary = r_binary;
  assign error  = r_error;

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 The block SHALL have the port bcd, input, 12 bits: three BCD digits; [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-005 The block SHALL have the port negative, input, 1 bit: sign of the BCD magnitude, 1 = negative.
REQ-006 The block SHALL have the port binary, output, 11 bits: signed two's-complement result, range -999..+999.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while a conversion is in progress (state SHIFT).
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking that binary and error are valid.
REQ-009 The block SHALL have the port error, output, 1 bit: the last request contained a digit greater than 9.

Function
REQ-010 The block SHALL implement exactly three states: IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL latch bcd and negative into internal registers; later input changes SHALL NOT affect the conversion.
REQ-012 On that start edge, if any latched digit is greater than 9, the block SHALL go directly to DONE with error=1 and binary=0.
REQ-013 On that start edge, if all digits are valid, the block SHALL go to SHIFT, clear the iteration counter to 0 and clear error.
REQ-014 Each rising edge in SHIFT SHALL perform one reverse double-dabble iteration on the 22-bit working register {bcd_reg[11:0], bin_reg[9:0]}:
  - shift the whole register right by 1;
  - then, for each of the three 4-bit BCD digit fields, subtract 3 if the shifted digit is 8 or more.
REQ-015 The iteration counter SHALL be 4 bits wide; after the 10th iteration the block SHALL go to DONE.
REQ-016 On entry to DONE, binary SHALL be loaded with {1'b0, bin_reg} when the latched negative is 0, and with the 11-bit two's complement of {1'b0, bin_reg} when it is 1.
REQ-017 A negative zero (negative=1, magnitude 0) SHALL produce binary=0.
REQ-018 Valid-input latency SHALL be 11 rising edges from the start edge to the edge that asserts done: 10 in SHIFT plus the DONE entry.
REQ-019 Invalid-input latency SHALL be 1 rising edge.
REQ-020 done SHALL be high for exactly one cycle, while in DONE.
REQ-021 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 binary and error SHALL hold their values until the next accepted start.
REQ-023 start SHALL be ignored in SHIFT and DONE; the block has no queuing, so a new request needs start sampled high in IDLE.
REQ-024 start held high continuously SHALL begin a new conversion on the edge after each return to IDLE, giving back-to-back conversions every 12 cycles.
REQ-025 busy SHALL be asserted iff the state is SHIFT; done and busy SHALL never be high together.
REQ-026 Maximum magnitude 999 SHALL fit bin_reg; no overflow is possible for valid input.

Reset
REQ-027 While rst=1, the block SHALL hold state IDLE, counter=0, binary=0, busy=0, done=0, error=0 and all internal registers at 0, regardless of clk.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion immediately, with no done pulse.
REQ-029 After rst deasserts, the first start sampled in IDLE SHALL begin a fresh conversion.

Verification
REQ-030 bcd=12'h255, negative=0, start pulse -> busy high for 10 cycles, then done pulse with binary=11'd255, error=0.
REQ-031 bcd=12'h999, negative=0 -> binary=11'd999 (11'h3E7); bcd=12'h000 -> binary=0.
REQ-032 bcd=12'h007, negative=1 -> binary=11'h7F9 (-7); bcd=12'h000, negative=1 -> binary=0.
REQ-033 bcd=12'h1A3 -> done on the edge after start, error=1, binary=0, busy never high; a following valid request clears error.
REQ-034 start re-pulsed during SHIFT with bcd changed to 12'h111 -> ignored; the result matches the originally latched value.
REQ-035 rst pulsed at iteration 5 -> all outputs 0 immediately, no done pulse; the next start converts 12'h042 -> binary=11'd42.
